// File: rtl/gate_en_sched.sv
// Enable sequencer for a shared AND2 gating stage: wakes on demand, waits a settle
// window before granting, and drops the enable after an idle hysteresis window.
module gate_en_sched #(
    parameter int N_REQ    = 4,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [N_REQ-1:0] req,
    input  logic             force_on,
    output logic             en,
    output logic [N_REQ-1:0] ack,
    output logic             active,
    output logic [1:0]       state_o
);

    localparam int MAX_CYC = (WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC;
    // Keep at least one bit so the counter stays legal when both windows are zero.
    localparam int CNT_W   = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        IDLE = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             demand;

    assign demand = (|req) | force_on;

    // en follows next_state so it changes in the same edge as the state itself.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= OFF;
            cnt   <= '0;
            en    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state <= next_state;
            cnt   <= cnt_next;
            en    <= (next_state != OFF);
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        next_state = state;
        cnt_next   = cnt;
        unique case (state)
            OFF: begin
                if (demand) begin
                    if (WAKE_CYC == 0) begin
                        next_state = ON;
                    end else begin
                        next_state = WAKE;
                        cnt_next   = CNT_W'(WAKE_CYC);
                    end
                end
            end
            WAKE: begin
                if (cnt == CNT_W'(1)) next_state = ON;
                else                  cnt_next   = cnt - CNT_W'(1);
            end
            ON: begin
                if (!demand) begin
                    if (IDLE_CYC == 0) begin
                        next_state = OFF;
                    end else begin
                        next_state = IDLE;
                        cnt_next   = CNT_W'(IDLE_CYC);
                    end
                end
            end
            IDLE: begin
                // Expiry wins over late demand: guarantees at least one OFF cycle.
                if (cnt == CNT_W'(1)) next_state = OFF;
                else if (demand)      next_state = ON;
                else                  cnt_next   = cnt - CNT_W'(1);
            end
            default: next_state = OFF;
        endcase
    end

    always_comb begin
        active  = (state == ON) || (state == IDLE);
        ack     = req & {N_REQ{active}};
        state_o = state;
    end

endmodule

// File: tb/tb_gate_en_sched.sv
// Scoreboard bench for gate_en_sched: three parameterisations share random stimulus,
// a deadline-based reference model queues expected outputs, a monitor compares them.
module tb_gate_en_sched;

    localparam int NCFG = 3;
    localparam int W_CFG [NCFG] = '{2, 0, 1};
    localparam int I_CFG [NCFG] = '{8, 0, 3};

    typedef struct {
        int         cfg;
        logic       en;
        logic [3:0] ack;
        logic       active;
        logic [1:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic [3:0] req = 4'b0;
    logic       force_on = 1'b0;

    logic       en_d     [NCFG];
    logic [3:0] ack_d    [NCFG];
    logic       active_d [NCFG];
    logic [1:0] state_d  [NCFG];

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Model: state in spec encoding plus the absolute cycle at which a timed phase ends.
    int   m_state [NCFG] = '{0, 0, 0};
    int   m_dead  [NCFG] = '{0, 0, 0};

    always #5 clk = ~clk;

    gate_en_sched #(.N_REQ(4), .WAKE_CYC(W_CFG[0]), .IDLE_CYC(I_CFG[0])) dut_a (
        .clk(clk), .rst_b(rst_b), .req(req), .force_on(force_on),
        .en(en_d[0]), .ack(ack_d[0]), .active(active_d[0]), .state_o(state_d[0]));

    gate_en_sched #(.N_REQ(4), .WAKE_CYC(W_CFG[1]), .IDLE_CYC(I_CFG[1])) dut_b (
        .clk(clk), .rst_b(rst_b), .req(req), .force_on(force_on),
        .en(en_d[1]), .ack(ack_d[1]), .active(active_d[1]), .state_o(state_d[1]));

    gate_en_sched #(.N_REQ(4), .WAKE_CYC(W_CFG[2]), .IDLE_CYC(I_CFG[2])) dut_c (
        .clk(clk), .rst_b(rst_b), .req(req), .force_on(force_on),
        .en(en_d[2]), .ack(ack_d[2]), .active(active_d[2]), .state_o(state_d[2]));

    task automatic check(input string name, input int c, input logic [7:0] act, input logic [7:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL cfg%0d %s cyc=%0d: got %0h want %0h", c, name, cyc, act, want);
        end
    endtask

    function automatic void advance(input int c, input bit d);
        case (m_state[c])
            0: if (d) begin
                if (W_CFG[c] == 0) m_state[c] = 2;
                else begin
                    m_state[c] = 1;
                    m_dead[c]  = cyc + 1 + W_CFG[c];
                end
            end
            1: if (cyc + 1 == m_dead[c]) m_state[c] = 2;
            2: if (!d) begin
                if (I_CFG[c] == 0) m_state[c] = 0;
                else begin
                    m_state[c] = 3;
                    m_dead[c]  = cyc + 1 + I_CFG[c];
                end
            end
            default: begin
                if (cyc + 1 == m_dead[c]) m_state[c] = 0;
                else if (d)               m_state[c] = 2;
            end
        endcase
    endfunction

    task automatic step(input logic [3:0] r, input logic f, input logic rst_low);
        exp_t e;
        @(posedge clk);
        #1;
        req      = r;
        force_on = f;
        rst_b    = ~rst_low;
        for (int c = 0; c < NCFG; c++) begin
            if (rst_low) m_state[c] = 0;
            e.cfg    = c;
            e.st     = 2'(m_state[c]);
            e.en     = (m_state[c] != 0);
            e.active = (m_state[c] >= 2);
            e.ack    = e.active ? r : 4'b0;
            exp_q.push_back(e);
            if (!rst_low) advance(c, (r != 4'b0) || f);
        end
        cyc++;
    endtask

    task automatic hold(input logic [3:0] r, input logic f, input int n);
        for (int k = 0; k < n; k++) step(r, f, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state_o", e.cfg, 8'(state_d[e.cfg]),  8'(e.st));
            check("en",      e.cfg, 8'(en_d[e.cfg]),     8'(e.en));
            check("active",  e.cfg, 8'(active_d[e.cfg]), 8'(e.active));
            check("ack",     e.cfg, 8'(ack_d[e.cfg]),    8'(e.ack));
        end
    end

    initial begin
        logic [3:0] cur;
        logic       f;
        // Reset held, then 20 idle cycles.
        for (int k = 0; k < 3; k++) step(4'b0, 1'b0, 1'b1);
        hold(4'b0000, 1'b0, 20);
        // Single requester wake, hold, release into IDLE, pulse another requester in IDLE.
        hold(4'b0001, 1'b0, 7);
        hold(4'b0000, 1'b0, 5);
        hold(4'b0100, 1'b0, 1);
        hold(4'b0000, 1'b0, 14);
        // Drop and immediately re-raise.
        hold(4'b0010, 1'b0, 5);
        hold(4'b0000, 1'b0, 1);
        hold(4'b0010, 1'b0, 4);
        hold(4'b0000, 1'b0, 14);
        // Debug override without requesters.
        hold(4'b0000, 1'b1, 10);
        hold(4'b0000, 1'b0, 14);
        // Two requesters together, then reset while ON.
        hold(4'b1001, 1'b0, 6);
        step(4'b1001, 1'b0, 1'b1);
        step(4'b1001, 1'b0, 1'b1);
        hold(4'b0000, 1'b0, 14);
        // Random traffic with sticky demand, idle gaps and occasional resets.
        cur = 4'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0)
                cur = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
            f = ($urandom_range(0, 31) == 0);
            step(cur, f, ($urandom_range(0, 499) == 0));
        end
        hold(4'b0000, 1'b0, 2);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
